// File: rtl/riscv_rf_pkg.sv
// Shared definitions for the RISC-V register file: default widths, the
// clear-sequencer state encoding and the architectural zero register.
package riscv_rf_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned ADDR_W_DEF = 5;

  // x0 is the hardwired-zero register of the RISC-V ISA.
  localparam int unsigned REG_ZERO = 0;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } rf_state_e;

endpackage

// File: rtl/rf_clear_seq.sv
// Sequential clear engine: after reset, walks every register-file entry once,
// issuing one zeroing write per cycle, then raises init_done_o and goes idle.
module rf_clear_seq
  import riscv_rf_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              init_done_o,
  output logic              clr_we_o,
  output logic [ADDR_W-1:0] clr_addr_o
);

  rf_state_e         state_q;
  logic [ADDR_W-1:0] clr_ptr_q;
  logic              init_done_q;

  // Clear FSM: one entry per cycle, finishing on the write of the last entry.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= CLEAR;
      clr_ptr_q   <= '0;
      init_done_q <= 1'b0;
    end else if (state_q == CLEAR) begin
      clr_ptr_q <= clr_ptr_q + 1'b1;
      if (clr_ptr_q == '1) begin
        state_q     <= READY;
        init_done_q <= 1'b1;
      end
    end
  end

  assign clr_we_o    = (state_q == CLEAR);
  assign clr_addr_o  = clr_ptr_q;
  assign init_done_o = init_done_q;

endmodule

// File: rtl/regfile_mp.sv
// Multi-read-port register file with one write port, optional write-to-read
// bypass, hardwired-zero x0 and a per-register busy scoreboard. Contents are
// zeroed after reset by rf_clear_seq, one entry per cycle.
module regfile_mp
  import riscv_rf_pkg::*;
#(
  parameter int unsigned DATA_W   = DATA_W_DEF,
  parameter int unsigned ADDR_W   = ADDR_W_DEF,
  parameter int unsigned NREAD    = 2,
  parameter bit          BYPASS   = 1'b1,
  parameter bit          ZERO_REG = 1'b1
) (
  input  logic                    clk,
  input  logic                    rst,
  output logic                    init_done,
  input  logic [NREAD*ADDR_W-1:0] rd_addr,
  output logic [NREAD*DATA_W-1:0] rd_data,
  output logic [NREAD-1:0]        rd_busy,
  input  logic                    wr_en,
  input  logic [ADDR_W-1:0]       wr_addr,
  input  logic [DATA_W-1:0]       wr_data,
  input  logic                    issue_en,
  input  logic [ADDR_W-1:0]       issue_addr
);

  localparam int unsigned       DEPTH     = 1 << ADDR_W;
  localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(REG_ZERO);

  logic              ready;
  logic              clr_we;
  logic [ADDR_W-1:0] clr_addr;

  logic              user_we;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q;
  logic [DEPTH-1:0]  busy_d;

  rf_clear_seq #(
    .ADDR_W(ADDR_W)
  ) u_clear_seq (
    .clk        (clk),
    .rst        (rst),
    .init_done_o(ready),
    .clr_we_o   (clr_we),
    .clr_addr_o (clr_addr)
  );

  assign init_done = ready;

  // Writeback is honoured only once the clear has finished; x0 writes vanish.
  assign user_we = ready && !rst && wr_en && !(ZERO_REG && (wr_addr == ZERO_ADDR));

  // Share the single storage write port between the clear engine and writeback.
  always_comb begin
    mem_we    = clr_we || user_we;
    mem_waddr = wr_addr;
    mem_wdata = wr_data;
    if (clr_we) begin
      mem_waddr = clr_addr;
      mem_wdata = '0;
    end
  end

  // Storage array write.
  // NOTE: the array has no reset branch; it is zeroed by the clear engine so
  // it maps onto plain RAM/flops without a wide reset fan-out.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem_q[mem_waddr] <= mem_wdata;
    end
  end

  // Scoreboard next state: writeback clears, issue sets, issue wins on a tie.
  // NOTE: busy_d takes a full default first so no path leaves it unassigned
  // and no latch is inferred.
  always_comb begin
    busy_d = busy_q;
    if (ready) begin
      if (wr_en) begin
        busy_d[wr_addr] = 1'b0;
      end
      if (issue_en) begin
        busy_d[issue_addr] = 1'b1;
      end
    end
    if (ZERO_REG) begin
      busy_d[ZERO_ADDR] = 1'b0;
    end
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q <= '0;
    end else begin
      busy_q <= busy_d;
    end
  end

  for (genvar i = 0; i < NREAD; i++) begin : g_rd
    logic [ADDR_W-1:0] ra;
    logic              fwd;
    logic [DATA_W-1:0] rdata;
    logic              rbusy;

    assign ra  = rd_addr[i*ADDR_W +: ADDR_W];
    assign fwd = BYPASS && wr_en && (wr_addr == ra);

    // Read port: clear gating, then x0, then same-cycle forward, then array.
    always_comb begin
      rdata = mem_q[ra];
      rbusy = busy_q[ra];
      if (!ready) begin
        rdata = '0;
        rbusy = 1'b0;
      end else if (ZERO_REG && (ra == ZERO_ADDR)) begin
        rdata = '0;
        rbusy = 1'b0;
      end else if (fwd) begin
        rdata = wr_data;
        rbusy = 1'b0;
      end
    end

    assign rd_data[i*DATA_W +: DATA_W] = rdata;
    assign rd_busy[i]                  = rbusy;
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Self-checking bench for regfile_mp: default build, a BYPASS=0 build and a
// wide NREAD=4 / ADDR_W=6 / DATA_W=64 build share clk and rst. Expectations are
// queued while stimulus is applied and compared when outputs settle.
module tb_regfile_mp;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;

  // Inputs shared by the default and no-bypass instances.
  logic [9:0]  rd_addr;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic        issue_en;
  logic [4:0]  issue_addr;

  logic [63:0] d0, d1;
  logic [1:0]  b0, b1;
  logic        i0, i1;

  // Wide instance.
  logic [23:0]  w_rd_addr;
  logic         w_wr_en;
  logic [5:0]   w_wr_addr;
  logic [63:0]  w_wr_data;
  logic         w_issue_en;
  logic [5:0]   w_issue_addr;
  logic [255:0] w_rd_data;
  logic [3:0]   w_rd_busy;
  logic         w_init;

  regfile_mp u_dflt (
    .clk(clk), .rst(rst), .init_done(i0),
    .rd_addr(rd_addr), .rd_data(d0), .rd_busy(b0),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );

  regfile_mp #(.BYPASS(1'b0)) u_nobyp (
    .clk(clk), .rst(rst), .init_done(i1),
    .rd_addr(rd_addr), .rd_data(d1), .rd_busy(b1),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .issue_en(issue_en), .issue_addr(issue_addr)
  );

  regfile_mp #(.DATA_W(64), .ADDR_W(6), .NREAD(4)) u_wide (
    .clk(clk), .rst(rst), .init_done(w_init),
    .rd_addr(w_rd_addr), .rd_data(w_rd_data), .rd_busy(w_rd_busy),
    .wr_en(w_wr_en), .wr_addr(w_wr_addr), .wr_data(w_wr_data),
    .issue_en(w_issue_en), .issue_addr(w_issue_addr)
  );

  typedef enum int {O_INIT, O_D0, O_D1, O_B0, O_B1, N_D1, N_B1,
                    W_INIT, W_D0, W_D1, W_D2, W_D3, W_B} obs_e;

  typedef struct {
    string       tag;
    obs_e        obs;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   n_checks = 0;
  int   n_pass   = 0;

  logic [63:0] w_model [64];

  function automatic logic [63:0] obs_val(obs_e o);
    logic [63:0] r;
    r = '1;
    case (o)
      O_INIT: r = {63'b0, i0};
      O_D0:   r = {32'b0, d0[31:0]};
      O_D1:   r = {32'b0, d0[63:32]};
      O_B0:   r = {63'b0, b0[0]};
      O_B1:   r = {63'b0, b0[1]};
      N_D1:   r = {32'b0, d1[63:32]};
      N_B1:   r = {63'b0, b1[1]};
      W_INIT: r = {63'b0, w_init};
      W_D0:   r = w_rd_data[63:0];
      W_D1:   r = w_rd_data[127:64];
      W_D2:   r = w_rd_data[191:128];
      W_D3:   r = w_rd_data[255:192];
      W_B:    r = {60'b0, w_rd_busy};
      default: r = '1;
    endcase
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
  endtask

  task automatic expect_v(input string tag, input obs_e o, input logic [63:0] e);
    exp_t x;
    x.tag = tag;
    x.obs = o;
    x.exp = e;
    sb_q.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    #2;
    while (sb_q.size() > 0) begin
      x = sb_q.pop_front();
      check(x.tag, obs_val(x.obs), x.exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_en      = 1'b0;
    issue_en   = 1'b0;
    w_wr_en    = 1'b0;
    w_issue_en = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    idle();
    rd_addr = '0; wr_addr = '0; wr_data = '0; issue_addr = '0;
    w_rd_addr = '0; w_wr_addr = '0; w_wr_data = '0; w_issue_addr = '0;
    next_cyc();
    rst = 1'b0;

    // 1. Clear: writes and issues during CLEAR are dropped.
    for (int k = 1; k <= 64; k++) begin
      if (k <= 32) begin
        wr_en = 1'b1; wr_addr = 5'(k); wr_data = 32'hC0DE_0000 | 32'(k);
        issue_en = 1'b1; issue_addr = 5'(k);
        rd_addr = {5'(k + 1), 5'(k)};
        expect_v($sformatf("init_low_c%0d", k), O_INIT, 64'd0);
        expect_v($sformatf("clr_rd_c%0d", k), O_D0, 64'd0);
        expect_v($sformatf("clr_busy_c%0d", k), O_B0, 64'd0);
      end else begin
        wr_en = 1'b0; issue_en = 1'b0;
        rd_addr = {5'd0, 5'(k - 33)};
        expect_v($sformatf("init_high_c%0d", k), O_INIT, 64'd1);
        expect_v($sformatf("cleared_x%0d", k - 33), O_D0, 64'd0);
        expect_v($sformatf("cleared_busy_x%0d", k - 33), O_B0, 64'd0);
      end
      w_wr_en = 1'b1; w_wr_addr = 6'(k); w_wr_data = 64'hFEED_0000_0000_0000 | 64'(k);
      w_issue_en = 1'b1; w_issue_addr = 6'(k);
      expect_v($sformatf("w_init_low_c%0d", k), W_INIT, 64'd0);
      drain();
      next_cyc();
    end
    idle();
    w_rd_addr = {6'd63, 6'd62, 6'd61, 6'd60};
    expect_v("w_init_high", W_INIT, 64'd1);
    expect_v("w_cleared_60", W_D0, 64'd0);
    expect_v("w_cleared_61", W_D1, 64'd0);
    expect_v("w_cleared_62", W_D2, 64'd0);
    expect_v("w_cleared_63", W_D3, 64'd0);
    expect_v("w_busy_clear", W_B, 64'd0);
    drain();
    next_cyc();

    // 2. Basic write/read and zero register.
    wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEADBEEF; rd_addr = {5'd0, 5'd5};
    expect_v("x5_bypass", O_D0, 64'hDEADBEEF);
    drain(); next_cyc();
    wr_en = 1'b0; rd_addr = {5'd5, 5'd5};
    expect_v("x5_read", O_D0, 64'hDEADBEEF);
    expect_v("x5_read_nobyp", N_D1, 64'hDEADBEEF);
    drain(); next_cyc();
    wr_en = 1'b1; wr_addr = 5'd0; wr_data = 32'h12345678; rd_addr = {5'd0, 5'd0};
    expect_v("x0_wr_cycle", O_D0, 64'd0);
    expect_v("x0_wr_cycle_p1", O_D1, 64'd0);
    drain(); next_cyc();
    wr_en = 1'b0;
    expect_v("x0_after", O_D0, 64'd0);
    expect_v("x0_after_nobyp", N_D1, 64'd0);
    drain(); next_cyc();

    // 3. Bypass versus no bypass on a busy register.
    issue_en = 1'b1; issue_addr = 5'd7; rd_addr = {5'd7, 5'd0};
    expect_v("x7_busy_not_yet", O_B1, 64'd0);
    drain(); next_cyc();
    issue_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'hA5A5A5A5;
    expect_v("x7_fwd_data", O_D1, 64'hA5A5A5A5);
    expect_v("x7_fwd_busy", O_B1, 64'd0);
    expect_v("x7_nobyp_old", N_D1, 64'd0);
    expect_v("x7_nobyp_busy", N_B1, 64'd1);
    drain(); next_cyc();
    wr_en = 1'b0;
    expect_v("x7_data_after", O_D1, 64'hA5A5A5A5);
    expect_v("x7_nobyp_after", N_D1, 64'hA5A5A5A5);
    expect_v("x7_busy_after", O_B1, 64'd0);
    expect_v("x7_nobyp_busy_after", N_B1, 64'd0);
    drain(); next_cyc();

    // 4. Scoreboard.
    issue_en = 1'b1; issue_addr = 5'd3; rd_addr = {5'd3, 5'd3};
    expect_v("x3_issue_cycle", O_B0, 64'd0);
    drain(); next_cyc();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h33;
    expect_v("x3_issue_wr_fwd", O_B0, 64'd0);
    expect_v("x3_issue_wr_nobyp", N_B1, 64'd1);
    drain(); next_cyc();
    idle();
    expect_v("x3_set_wins", O_B0, 64'd1);
    expect_v("x3_set_wins_nobyp", N_B1, 64'd1);
    drain(); next_cyc();
    wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h44;
    expect_v("x3_wb_fwd_busy", O_B0, 64'd0);
    expect_v("x3_wb_nobyp_busy", N_B1, 64'd1);
    drain(); next_cyc();
    idle();
    expect_v("x3_cleared", O_B0, 64'd0);
    expect_v("x3_data", O_D0, 64'h44);
    expect_v("x3_cleared_nobyp", N_B1, 64'd0);
    drain(); next_cyc();
    issue_en = 1'b1; issue_addr = 5'd4; rd_addr = {5'd4, 5'd4};
    drain(); next_cyc();
    expect_v("x4_busy", O_B0, 64'd1);
    drain(); next_cyc();
    issue_en = 1'b0; wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h55;
    drain(); next_cyc();
    idle();
    expect_v("x4_single_wb", O_B0, 64'd0);
    expect_v("x4_single_wb_nobyp", N_B1, 64'd0);
    drain(); next_cyc();
    issue_en = 1'b1; issue_addr = 5'd0; rd_addr = {5'd0, 5'd0};
    drain(); next_cyc();
    idle();
    expect_v("x0_never_busy", O_B0, 64'd0);
    expect_v("x0_never_busy_nobyp", N_B1, 64'd0);
    drain(); next_cyc();

    // 6. Wide instance: four ports reading distinct registers.
    for (int j = 0; j < 4; j++) begin
      w_wr_en = 1'b1; w_wr_addr = 6'(j * 17 + 1);
      w_wr_data = {32'hBADC0000 | 32'(j), 32'h01234567 + 32'(j * 1000)};
      w_model[j * 17 + 1] = w_wr_data;
      drain(); next_cyc();
    end
    idle();
    w_rd_addr = {6'd1, 6'd18, 6'd35, 6'd52};
    expect_v("w_p0_x52", W_D0, w_model[52]);
    expect_v("w_p1_x35", W_D1, w_model[35]);
    expect_v("w_p2_x18", W_D2, w_model[18]);
    expect_v("w_p3_x1", W_D3, w_model[1]);
    drain(); next_cyc();
    w_rd_addr = {6'd35, 6'd0, 6'd52, 6'd18};
    expect_v("w_p0_x18", W_D0, w_model[18]);
    expect_v("w_p1_x52", W_D1, w_model[52]);
    expect_v("w_p2_x0", W_D2, 64'd0);
    expect_v("w_p3_x35", W_D3, w_model[35]);
    drain(); next_cyc();

    // 5. Reset in the middle of a clear restarts it.
    wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
    issue_en = 1'b1; issue_addr = 5'd9; rd_addr = {5'd9, 5'd9};
    drain(); next_cyc();
    idle();
    expect_v("x9_pre_busy", O_B0, 64'd1);
    expect_v("x9_pre_data", O_D0, 64'h99);
    drain(); next_cyc();
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      expect_v($sformatf("mid_init_low_c%0d", k), O_INIT, 64'd0);
      drain(); next_cyc();
    end
    rst = 1'b1;
    next_cyc();
    rst = 1'b0;
    for (int k = 1; k <= 32; k++) begin
      expect_v($sformatf("restart_init_low_c%0d", k), O_INIT, 64'd0);
      drain(); next_cyc();
    end
    expect_v("restart_init_high", O_INIT, 64'd1);
    expect_v("x9_cleared", O_D0, 64'd0);
    expect_v("x9_busy_p0", O_B0, 64'd0);
    expect_v("x9_busy_p1", O_B1, 64'd0);
    drain(); next_cyc();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-read-port register file for the RISC-V datapath core.
- Provides NREAD combinational read ports and one synchronous write port.
- Adds optional write-to-read bypass, a hardwired-zero register 0, and a per-register busy scoreboard for hazard detection.
- Replaces the single-cycle bulk reset with a sequential clear engine that zeroes one entry per cycle and reports completion on init_done.

Parameters:
- DATA_W, 32, register width in bits.
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries.
- NREAD, 2, number of read ports (1..4).
- BYPASS, 1, 1 = a same-cycle write is forwarded to matching read ports and busy outputs.
- ZERO_REG, 1, 1 = register 0 always reads 0, ignores writes, and is never busy.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- init_done  out  1  high once the clear sequence has finished.
- rd_addr  in  NREAD*ADDR_W  packed read addresses; port i occupies bits [i*ADDR_W +: ADDR_W].
- rd_data  out  NREAD*DATA_W  packed read data, combinational.
- rd_busy  out  NREAD  busy flag of each read port's addressed register, combinational.
- wr_en  in  1  write enable (writeback).
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- issue_en  in  1  mark issue_addr busy (pending producer).
- issue_addr  in  ADDR_W  destination register of the issued instruction.

Behaviour:

FSM states: CLEAR, READY.

On rst (sampled at clk edge):
- state <= CLEAR, clr_ptr <= 0, busy <= all 0, init_done <= 0.
- rst asserted mid-clear restarts the sequence from entry 0.
- Register contents are not reset directly.

CLEAR:
- Each cycle: mem[clr_ptr] <= 0, clr_ptr <= clr_ptr+1.
- On the cycle that writes DEPTH-1: state <= READY, init_done <= 1.
- With rst high in cycle 0 and low from cycle 1, the clear runs in cycles 1..DEPTH and init_done reads 1 from cycle DEPTH+1.
- In CLEAR: wr_en and issue_en are ignored; all rd_data = 0; all rd_busy = 0.

READY, write:
- wr_en=1 gives mem[wr_addr] <= wr_data at the edge.
- If ZERO_REG and wr_addr==0, the write is dropped.

READY, read port i (combinational):
- If ZERO_REG and rd_addr_i==0: rd_data_i = 0.
- Else if BYPASS and wr_en and wr_addr==rd_addr_i: rd_data_i = wr_data.
- Else: rd_data_i = mem[rd_addr_i].
- With BYPASS=0, a read of the register being written returns the old value until the next cycle.

Scoreboard:
- busy[DEPTH] is registered.
- At each edge in READY:
  - wr_en clears busy[wr_addr].
  - issue_en sets busy[issue_addr].
- Same address in both: the set wins (new producer supersedes the writeback).
- ZERO_REG: busy[0] is held at 0.
- rd_busy_i = busy[rd_addr_i], forced 0 when BYPASS and wr_en and wr_addr==rd_addr_i (the value is being forwarded this cycle).
- Issue to an already-busy register is legal; the flag stays 1 and a single writeback clears it.

Ports are independent:
- Multiple read ports may address the same register.
- No read-side arbitration.

Latency:
- Write to architectural visibility: 1 edge, or 0 with BYPASS.
- Issue to busy visible: 1 edge.

Decomposition:
- Shared package riscv_rf_pkg: DATA_W and ADDR_W defaults, the CLEAR/READY state encoding, and the REG_ZERO constant.
- One sub-module, rf_clear_seq: holds the state register, clr_ptr counter and init_done. It exports clr_we and clr_addr, which are muxed onto the write port.
- Storage, bypass and scoreboard live in regfile_mp.

Test Plan:
1. Reset clear (defaults): pulse rst 1 cycle, then hold wr_en=1 with non-zero data during the clear -> init_done low for exactly 32 cycles, then high; all 32 registers then read 0; every write issued during CLEAR is lost.
2. Basic write/read and zero register: write x5=0xDEADBEEF, next cycle rd_addr0=5 -> 0xDEADBEEF; write x0=0x12345678 -> x0 reads 0.
3. Bypass, BYPASS=1: wr_en with x7=0xA5A5A5A5 while rd_addr1=7 in the same cycle -> rd_data1=0xA5A5A5A5 and rd_busy1=0 that cycle. Rerun with BYPASS=0 -> the old value (0) is returned until the next cycle.
4. Scoreboard: issue x3 -> rd_busy=1 on x3 next cycle; issue x3 and wr_en x3 in the same cycle -> stays busy; a later wr_en x3 -> busy clears; issue x0 -> x0 never busy.
5. Mid-clear reset: assert rst at clear cycle 10 -> clr_ptr restarts at 0 and init_done rises DEPTH cycles after rst falls; busy is all 0.
6. Parameter sweep at NREAD=4, ADDR_W=6, DATA_W=64: all 4 ports read distinct registers in one cycle with correct data; clear takes 64 cycles.
